lcd_rgb_frame_writer: RTL and testbench

- Receiver end of the parallel RGB565 LCD interface: samples DE/HSYNC/VSYNC/RGB in the pixel clock domain.
- Converts each pixel to 8-bit grayscale, crops an IMG_W x IMG_H window and writes it raster-order into the grayscale frame-buffer BRAM port A.
- The blur/display path then reads that BRAM.
- Capture is one-shot per start request, with an optional continuous mode.

---
 rtl/lcd_rgb_frame_writer.sv | 187 ++++++++++++++++++
 tb/tb_lcd_rgb_frame_writer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_frame_writer.sv
// lcd_rgb_frame_writer
// Receiver end of a parallel RGB565 LCD bus. Each pixel is converted to 8-bit
// grayscale. A rectangular IMG_W x IMG_H window is cropped from the frame and
// written in raster order to port A of the grayscale frame-buffer BRAM.
// Capture is one-shot per start request.
// Optional macro LCD_RGB_FRAME_WRITER_CONTINUOUS_EN: after the first start,
// the block re-arms itself after every frame (done or error). It then captures
// every frame and stays busy.
module lcd_rgb_frame_writer #(
    parameter int IMG_W  = 252,
    parameter int IMG_H  = 156,
    parameter int X0     = 274,
    parameter int Y0     = 162,
    parameter int ADDR_W = 16
) (
    input  logic              PixelClk,
    input  logic              nRST,
    input  logic              start,
    input  logic              LCD_DE,
    input  logic              LCD_HSYNC,
    input  logic              LCD_VSYNC,
    input  logic [4:0]        LCD_R,
    input  logic [5:0]        LCD_G,
    input  logic [4:0]        LCD_B,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        CAPTURE,
        DONE
    } state_t;

    localparam logic [11:0]       CNT_MAX   = 12'hFFF;
    localparam logic [11:0]       X_LO      = 12'(X0);
    localparam logic [11:0]       X_HI      = 12'(X0 + IMG_W);
    localparam logic [11:0]       Y_LO      = 12'(Y0);
    localparam logic [11:0]       Y_HI      = 12'(Y0 + IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

`ifdef LCD_RGB_FRAME_WRITER_CONTINUOUS_EN
    localparam state_t REARM_STATE = WAIT_VS;
`else
    localparam state_t REARM_STATE = IDLE;
`endif

    logic        de_q, hs_q, vs_q;
    logic [4:0]  r_q, b_q;
    logic [5:0]  g_q;
    logic        de_d, vs_d;
    logic [11:0] col_cnt, line_cnt;

    logic        de_fall, vs_rise, vs_fall;
    logic [7:0]  r8, g8, b8, gray;
    logic        in_window;

    state_t            state, state_nx;
    logic              wr_en_nx, frame_err_nx;
    logic [ADDR_W-1:0] wr_addr_nx;
    logic [7:0]        wr_data_nx;

    // HSYNC is only carried through the input register; nothing consumes it.
    logic hsync_unused;
    assign hsync_unused = hs_q;

    // Input register stage, plus one-cycle-delayed copies of DE and VSYNC for edge detection.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            de_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            de_q <= LCD_DE;
            hs_q <= LCD_HSYNC;
            vs_q <= LCD_VSYNC;
            r_q  <= LCD_R;
            g_q  <= LCD_G;
            b_q  <= LCD_B;
            de_d <= de_q;
            vs_d <= vs_q;
        end
    end

    assign de_fall = de_d & ~de_q;
    assign vs_rise = vs_q & ~vs_d;
    assign vs_fall = ~vs_q & vs_d;

    // Column and line position of the registered pixel. Both counters saturate and never wrap.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            col_cnt  <= '0;
            line_cnt <= '0;
        end else begin
            if (!de_q)
                col_cnt <= '0;
            else if (col_cnt != CNT_MAX)
                col_cnt <= col_cnt + 12'd1;

            if (vs_q)
                line_cnt <= '0;
            else if (de_fall && line_cnt != CNT_MAX)
                line_cnt <= line_cnt + 12'd1;
        end
    end

    // Widen each channel to 8 bits, then form the weighted sum. The maximum is 236, so it cannot overflow.
    always_comb begin
        r8   = {r_q, r_q[4:2]};
        g8   = {g_q, g_q[5:4]};
        b8   = {b_q, b_q[4:2]};
        gray = (r8 >> 2) + (g8 >> 1) + (b8 >> 3) + (b8 >> 4);
    end

    assign in_window = de_q &&
                       (col_cnt  >= X_LO) && (col_cnt  < X_HI) &&
                       (line_cnt >= Y_LO) && (line_cnt < Y_HI);

    // State register and registered write-port and pulse outputs.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_en     <= wr_en_nx;
            wr_addr   <= wr_addr_nx;
            wr_data   <= wr_data_nx;
            frame_err <= frame_err_nx;
        end
    end

    // Next-state logic. The address advances after every issued write. Completion takes priority over an error.
    always_comb begin
        state_nx     = state;
        wr_en_nx     = 1'b0;
        wr_addr_nx   = wr_addr + ADDR_W'(wr_en);
        wr_data_nx   = wr_data;
        frame_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nx = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall) begin
                    state_nx   = CAPTURE;
                    wr_addr_nx = '0;
                end
            end
            CAPTURE: begin
                if (wr_en && wr_addr == LAST_ADDR) begin
                    state_nx = DONE;
                end else if (vs_rise) begin
                    state_nx     = REARM_STATE;
                    frame_err_nx = 1'b1;
                end else if (in_window) begin
                    wr_en_nx   = 1'b1;
                    wr_data_nx = gray;
                end
            end
            DONE: begin
                state_nx = REARM_STATE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_lcd_rgb_frame_writer.sv
// tb_lcd_rgb_frame_writer
// Drives directed RGB565 frames into lcd_rgb_frame_writer with a reduced window.
// The reduced window keeps every frame short.
// A queue-based pixel model predicts every frame-buffer write from the frame
// contents and the window rules.
// Build with LCD_RGB_FRAME_WRITER_CONTINUOUS_EN to exercise continuous mode.
module tb_lcd_rgb_frame_writer;

    localparam int IMG_W   = 16;
    localparam int IMG_H   = 5;
    localparam int X0      = 20;
    localparam int Y0      = 4;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 48;
    localparam int HBL     = 8;
    localparam int N_LINES = 12;
    localparam int VS_LEN  = 4;
    localparam int PORCH   = 3;
    localparam int N_PIX   = IMG_W * IMG_H;

    logic              PixelClk;
    logic              nRST;
    logic              start;
    logic              LCD_DE, LCD_HSYNC, LCD_VSYNC;
    logic [4:0]        LCD_R, LCD_B;
    logic [5:0]        LCD_G;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy, frame_done, frame_err;

    lcd_rgb_frame_writer #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .X0    (X0),
        .Y0    (Y0),
        .ADDR_W(ADDR_W)
    ) dut (
        .PixelClk  (PixelClk),
        .nRST      (nRST),
        .start     (start),
        .LCD_DE    (LCD_DE),
        .LCD_HSYNC (LCD_HSYNC),
        .LCD_VSYNC (LCD_VSYNC),
        .LCD_R     (LCD_R),
        .LCD_G     (LCD_G),
        .LCD_B     (LCD_B),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    int exp_addr[$];
    int exp_data[$];

    int   wr_count, done_count, err_count;
    int   first_wr_cyc, last_wr_cyc, done_cyc, first_pix_cyc;
    logic busy_after_done;
    logic [7:0] mem [0:N_PIX-1];

    // Free-running pixel clock and cycle counter.
    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;
    always @(posedge PixelClk) cyc <= cyc + 1;

    // Watchdog that stops a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "[TB] watchdog expired");
    end

    // Records one comparison; reports it on a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Gray value computed from the channel definitions with plain arithmetic.
    function automatic int gray_of(input int r, input int g, input int b);
        int r8, g8, b8;
        r8 = r * 8 + r / 4;
        g8 = g * 4 + g / 16;
        b8 = b * 8 + b / 4;
        return r8 / 4 + g8 / 2 + b8 / 8 + b8 / 16;
    endfunction

    // Test pattern: 0 = white, 1 = red ramp (col mod 32), otherwise a mixed pattern.
    function automatic logic [15:0] pix(input int mode, input int ln, input int col);
        int r, g, b;
        case (mode)
            0: begin r = 31; g = 63; b = 31; end
            1: begin r = col % 32; g = 0; b = 0; end
            default: begin
                r = (col + ln) % 32;
                g = (3 * col + ln) % 64;
                b = (7 * ln + col) % 32;
            end
        endcase
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    function automatic bit in_win(input int ln, input int col);
        return (ln >= Y0) && (ln < Y0 + IMG_H) && (col >= X0) && (col < X0 + IMG_W);
    endfunction

    // Model: queue the writes a frame with nlines active lines should produce.
    task automatic push_expected(input int mode, input int nlines);
        logic [15:0] p;
        for (int ln = 0; ln < nlines; ln++)
            for (int col = 0; col < LINE_W; col++)
                if (in_win(ln, col)) begin
                    p = pix(mode, ln, col);
                    exp_addr.push_back((ln - Y0) * IMG_W + (col - X0));
                    exp_data.push_back(gray_of(int'(p[15:11]), int'(p[10:5]), int'(p[4:0])));
                end
    endtask

    task automatic reset_track();
        wr_count = 0; done_count = 0; err_count = 0;
        first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1; first_pix_cyc = -1;
        busy_after_done = 1'bx;
    endtask

    task automatic drive(input logic de, input logic vs, input logic [15:0] p);
        @(negedge PixelClk);
        LCD_DE    = de;
        LCD_VSYNC = vs;
        LCD_HSYNC = ~de;
        {LCD_R, LCD_G, LCD_B} = p;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge PixelClk);
    endtask

    task automatic pulse_start();
        @(negedge PixelClk);
        start = 1'b1;
        @(negedge PixelClk);
        start = 1'b0;
    endtask

    // One frame: VSYNC blanking, back porch, nlines DE lines of LINE_W pixels, front porch.
    task automatic applyStimulus(input int mode, input int nlines);
        for (int i = 0; i < VS_LEN; i++) drive(1'b0, 1'b1, 16'h0);
        for (int i = 0; i < PORCH; i++) drive(1'b0, 1'b0, 16'h0);
        for (int ln = 0; ln < nlines; ln++) begin
            for (int col = 0; col < LINE_W; col++) begin
                drive(1'b1, 1'b0, pix(mode, ln, col));
                if (first_pix_cyc < 0 && in_win(ln, col)) first_pix_cyc = cyc;
            end
            for (int i = 0; i < HBL; i++) drive(1'b0, 1'b0, 16'h0);
        end
        for (int i = 0; i < PORCH; i++) drive(1'b0, 1'b0, 16'h0);
    endtask

    task automatic vsync_edge();
        for (int i = 0; i < VS_LEN; i++) drive(1'b0, 1'b1, 16'h0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b0, 16'h0);
    endtask

    // Compare process: every write must match the head of the model queue.
    // Writes never coincide with the done/err pulses.
    always @(negedge PixelClk) begin
        if (nRST) begin
            if (wr_en) begin
                wr_count++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (wr_addr == ADDR_W'(N_PIX - 1)) last_wr_cyc = cyc;
                if (wr_addr < ADDR_W'(N_PIX)) mem[wr_addr] = wr_data;
                if (exp_addr.size() == 0) begin
                    checkOutput("write_while_none_expected", 32'(wr_en), 0);
                end else begin
                    checkOutput("wr_addr", 32'(wr_addr), exp_addr.pop_front());
                    checkOutput("wr_data", 32'(wr_data), exp_data.pop_front());
                end
            end
            if (frame_done) begin
                done_count++;
                done_cyc = cyc;
                checkOutput("wr_en_with_done", 32'(wr_en), 0);
            end
            if (frame_err) begin
                err_count++;
                checkOutput("wr_en_with_err", 32'(wr_en), 0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
        end
    end

    initial begin
        nRST = 1'b0; start = 1'b0;
        LCD_DE = 1'b0; LCD_HSYNC = 1'b1; LCD_VSYNC = 1'b0;
        LCD_R = '0; LCD_G = '0; LCD_B = '0;
        reset_track();
        idle(5);
        checkOutput("rst_wr_en", 32'(wr_en), 0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 0);
        checkOutput("rst_wr_data", 32'(wr_data), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_frame_done", 32'(frame_done), 0);
        checkOutput("rst_frame_err", 32'(frame_err), 0);
        nRST = 1'b1;
        idle(2);

        checkOutput("model_white", gray_of(31, 63, 31), 236);
        checkOutput("model_red20", gray_of(20, 0, 0), 41);
        checkOutput("model_red3", gray_of(3, 0, 0), 6);

`ifdef LCD_RGB_FRAME_WRITER_CONTINUOUS_EN
        // Continuous: one start, three frames, every window restarting at address 0.
        reset_track();
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            push_expected(f == 1 ? 1 : 2, N_LINES);
            applyStimulus(f == 1 ? 1 : 2, N_LINES);
        end
        idle(4);
        checkOutput("cont_done_count", done_count, 3);
        checkOutput("cont_err_count", err_count, 0);
        checkOutput("cont_write_count", wr_count, 3 * N_PIX);
        checkOutput("cont_queue_left", exp_addr.size(), 0);
        checkOutput("cont_busy", 32'(busy), 1);
        checkOutput("cont_mixed_addr0", 32'(mem[0]), 73);
`else
        // Idle: a full frame without start produces no writes.
        reset_track();
        applyStimulus(0, N_LINES);
        vsync_edge();
        checkOutput("idle_writes", wr_count, 0);
        checkOutput("idle_busy", 32'(busy), 0);
        checkOutput("idle_done", done_count, 0);

        // White window.
        reset_track();
        pulse_start();
        checkOutput("busy_after_start", 32'(busy), 1);
        push_expected(0, N_LINES);
        applyStimulus(0, N_LINES);
        idle(4);
        checkOutput("white_queue_left", exp_addr.size(), 0);
        checkOutput("white_writes", wr_count, N_PIX);
        checkOutput("white_done_count", done_count, 1);
        checkOutput("white_err_count", err_count, 0);
        checkOutput("white_latency", first_wr_cyc - first_pix_cyc, 2);
        checkOutput("white_done_after_last", done_cyc - last_wr_cyc, 1);
        checkOutput("white_busy_after_done", 32'(busy_after_done), 0);
        checkOutput("white_data0", 32'(mem[0]), 236);

        // Gradient position check.
        reset_track();
        pulse_start();
        push_expected(1, N_LINES);
        applyStimulus(1, N_LINES);
        idle(4);
        checkOutput("grad_addr0", 32'(mem[0]), 41);
        checkOutput("grad_addr15", 32'(mem[15]), 6);
        checkOutput("grad_addr16", 32'(mem[16]), 41);
        checkOutput("grad_done_count", done_count, 1);
        checkOutput("grad_queue_left", exp_addr.size(), 0);

        // Mixed pattern with a start request arriving mid-capture.
        reset_track();
        pulse_start();
        push_expected(2, N_LINES);
        fork
            applyStimulus(2, N_LINES);
            begin idle(30); pulse_start(); end
        join
        idle(4);
        checkOutput("mixed_addr0", 32'(mem[0]), 73);
        checkOutput("mixed_done_count", done_count, 1);
        checkOutput("mixed_queue_left", exp_addr.size(), 0);
        checkOutput("mixed_busy", 32'(busy), 0);

        // Short frame: 6 active lines, then VSYNC rises.
        reset_track();
        pulse_start();
        push_expected(2, 6);
        applyStimulus(2, 6);
        vsync_edge();
        idle(3);
        checkOutput("short_err_count", err_count, 1);
        checkOutput("short_done_count", done_count, 0);
        checkOutput("short_writes", wr_count, 32);
        checkOutput("short_wr_addr", 32'(wr_addr), 32);
        checkOutput("short_busy", 32'(busy), 0);
        checkOutput("short_queue_left", exp_addr.size(), 0);

        // Reset asserted at write address 40.
        reset_track();
        pulse_start();
        push_expected(0, N_LINES);
        fork
            applyStimulus(0, N_LINES);
            begin : watch
                int k;
                for (k = 0; k < 3000 && !(wr_en === 1'b1 && wr_addr === 16'd40); k++)
                    @(negedge PixelClk);
                if (k >= 3000) begin
                    checkOutput("reset_trigger_timeout", 32'(wr_addr), 40);
                end else begin
                    #2 nRST = 1'b0;
                    #1;
                    checkOutput("wr_en_at_reset", 32'(wr_en), 0);
                    checkOutput("wr_addr_at_reset", 32'(wr_addr), 0);
                    checkOutput("busy_at_reset", 32'(busy), 0);
                    exp_addr.delete();
                    exp_data.delete();
                    idle(3);
                    nRST = 1'b1;
                end
            end
        join
        applyStimulus(0, N_LINES);
        vsync_edge();
        checkOutput("rst_mid_writes", wr_count, 41);
        checkOutput("rst_mid_done", done_count, 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
